ethernet_packet_receiver: RTL

//  Receive end of the packet generator's serial link. Deserialises the one-bit
//  'packet' stream qualified by 'packetValid' into header fields (dMAC, sMAC,

---
 rtl/ethernet_packet_receiver.sv | 312 +++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/ethernet_packet_receiver.sv
// ethernet_packet_receiver
//   Receive end of a one-bit serial frame link. A frame is a contiguous run of
//   bits with packetValid=1, MSB of each field first:
//     dMAC(48) sMAC(48) length(16) payload(length*8) FCS(32)
//   Header fields are shifted into working registers and copied to the header
//   outputs only when a frame completes cleanly. Payload bytes are streamed out
//   one cycle after their last bit. Malformed, truncated and overlong frames
//   raise frameError with a reason code.
//
// Ports
//   clock        in   1   system clock, rising edge
//   reset        in   1   asynchronous active-low reset
//   packet       in   1   serial frame bit
//   packetValid  in   1   qualifies packet; high for every bit of a frame
//   dMAC         out  48  destination MAC of last good frame
//   sMAC         out  48  source MAC of last good frame
//   length       out  16  payload length of last good frame
//   FCS          out  32  FCS field of last good frame (not checked)
//   dout         out  8   payload byte
//   dout_valid   out  1   one-cycle strobe qualifying dout
//   frameDone    out  1   one-cycle pulse, frame received without error
//   frameError   out  1   one-cycle pulse, frame aborted
//   errCode      out  2   0 none, 1 bad length, 2 truncated, 3 overrun
//   busy         out  1   receiver is inside a frame or draining
//
// State table
//   S_IDLE  | waiting for packetValid; first valid bit is dMAC[47]
//   S_DMAC  | shifting remaining 47 dMAC bits
//   S_SMAC  | shifting 48 sMAC bits
//   S_LEN   | shifting 16 length bits, length checked on the last one
//   S_PAY   | shifting payload, one byte per 8 bits
//   S_FCS   | shifting 32 FCS bits
//   S_END   | frame must end here: packetValid=0 -> done, 1 -> overrun
//   S_DRAIN | discarding the rest of a rejected frame

module ethernet_packet_receiver #(
  parameter int unsigned MAX_LEN = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        packet,
  input  logic        packetValid,
  output logic [47:0] dMAC,
  output logic [47:0] sMAC,
  output logic [15:0] length,
  output logic [31:0] FCS,
  output logic [7:0]  dout,
  output logic        dout_valid,
  output logic        frameDone,
  output logic        frameError,
  output logic [1:0]  errCode,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_DMAC,
    S_SMAC,
    S_LEN,
    S_PAY,
    S_FCS,
    S_END,
    S_DRAIN
  } state_e;

  localparam logic [15:0] MAX_LEN_W = 16'(MAX_LEN);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_LEN   = 2'd1;
  localparam logic [1:0] ERR_TRUNC = 2'd2;
  localparam logic [1:0] ERR_OVER  = 2'd3;

  state_e      state_q,       state_d;
  // Bits remaining in the current field minus one; terminal count is zero.
  logic [5:0]  cnt_q,         cnt_d;
  logic [15:0] byte_cnt_q,    byte_cnt_d;
  logic [47:0] dmac_sh_q,     dmac_sh_d;
  logic [47:0] smac_sh_q,     smac_sh_d;
  // Also serves as the latched length for the payload byte compare.
  logic [15:0] len_sh_q,      len_sh_d;
  logic [31:0] fcs_sh_q,      fcs_sh_d;
  logic [7:0]  byte_sh_q,     byte_sh_d;
  logic        byte_rdy_q,    byte_rdy_d;

  logic [47:0] dmac_q,        dmac_d;
  logic [47:0] smac_q,        smac_d;
  logic [15:0] length_q,      length_d;
  logic [31:0] fcs_q,         fcs_d;
  logic [7:0]  dout_q,        dout_d;
  logic        dout_valid_q,  dout_valid_d;
  logic        frame_done_q,  frame_done_d;
  logic        frame_error_q, frame_error_d;
  logic [1:0]  err_code_q,    err_code_d;
  logic        busy_q,        busy_d;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    byte_cnt_d    = byte_cnt_q;
    dmac_sh_d     = dmac_sh_q;
    smac_sh_d     = smac_sh_q;
    len_sh_d      = len_sh_q;
    fcs_sh_d      = fcs_sh_q;
    byte_sh_d     = byte_sh_q;
    byte_rdy_d    = 1'b0;
    dmac_d        = dmac_q;
    smac_d        = smac_q;
    length_d      = length_q;
    fcs_d         = fcs_q;
    dout_d        = dout_q;
    dout_valid_d  = 1'b0;
    frame_done_d  = 1'b0;
    frame_error_d = 1'b0;
    err_code_d    = err_code_q;

    // A completed byte is emitted on the following edge whatever happens to
    // the frame on that edge, so a byte finished just before a truncation
    // still reaches the sink.
    if (byte_rdy_q) begin
      dout_d       = byte_sh_q;
      dout_valid_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (packetValid) begin
          dmac_sh_d  = {dmac_sh_q[46:0], packet};
          err_code_d = ERR_NONE;
          cnt_d      = 6'd46;
          state_d    = S_DMAC;
        end
      end

      S_DMAC: begin
        if (!packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TRUNC;
          state_d       = S_IDLE;
        end else begin
          dmac_sh_d = {dmac_sh_q[46:0], packet};
          if (cnt_q == 6'd0) begin
            cnt_d   = 6'd47;
            state_d = S_SMAC;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_SMAC: begin
        if (!packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TRUNC;
          state_d       = S_IDLE;
        end else begin
          smac_sh_d = {smac_sh_q[46:0], packet};
          if (cnt_q == 6'd0) begin
            cnt_d   = 6'd15;
            state_d = S_LEN;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_LEN: begin
        if (!packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TRUNC;
          state_d       = S_IDLE;
        end else begin
          len_sh_d = {len_sh_q[14:0], packet};
          if (cnt_q == 6'd0) begin
            // Checked with the final length bit included, so a bad length is
            // reported on the same edge that completes the field.
            if ((len_sh_d == 16'd0) || (len_sh_d > MAX_LEN_W)) begin
              frame_error_d = 1'b1;
              err_code_d    = ERR_LEN;
              state_d       = S_DRAIN;
            end else begin
              cnt_d      = 6'd7;
              byte_cnt_d = 16'd0;
              state_d    = S_PAY;
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_PAY: begin
        if (!packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TRUNC;
          state_d       = S_IDLE;
        end else begin
          byte_sh_d = {byte_sh_q[6:0], packet};
          if (cnt_q[2:0] == 3'd0) begin
            byte_rdy_d = 1'b1;
            byte_cnt_d = byte_cnt_q + 16'd1;
            if (byte_cnt_d == len_sh_q) begin
              cnt_d   = 6'd31;
              state_d = S_FCS;
            end else begin
              cnt_d = 6'd7;
            end
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_FCS: begin
        if (!packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_TRUNC;
          state_d       = S_IDLE;
        end else begin
          fcs_sh_d = {fcs_sh_q[30:0], packet};
          if (cnt_q == 6'd0) begin
            state_d = S_END;
          end else begin
            cnt_d = cnt_q - 6'd1;
          end
        end
      end

      S_END: begin
        if (packetValid) begin
          frame_error_d = 1'b1;
          err_code_d    = ERR_OVER;
          state_d       = S_DRAIN;
        end else begin
          dmac_d       = dmac_sh_q;
          smac_d       = smac_sh_q;
          length_d     = len_sh_q;
          fcs_d        = fcs_sh_q;
          frame_done_d = 1'b1;
          state_d      = S_IDLE;
        end
      end

      S_DRAIN: begin
        if (!packetValid) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= 6'd0;
      byte_cnt_q    <= 16'd0;
      dmac_sh_q     <= 48'd0;
      smac_sh_q     <= 48'd0;
      len_sh_q      <= 16'd0;
      fcs_sh_q      <= 32'd0;
      byte_sh_q     <= 8'd0;
      byte_rdy_q    <= 1'b0;
      dmac_q        <= 48'd0;
      smac_q        <= 48'd0;
      length_q      <= 16'd0;
      fcs_q         <= 32'd0;
      dout_q        <= 8'd0;
      dout_valid_q  <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_error_q <= 1'b0;
      err_code_q    <= 2'd0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      dmac_sh_q     <= dmac_sh_d;
      smac_sh_q     <= smac_sh_d;
      len_sh_q      <= len_sh_d;
      fcs_sh_q      <= fcs_sh_d;
      byte_sh_q     <= byte_sh_d;
      byte_rdy_q    <= byte_rdy_d;
      dmac_q        <= dmac_d;
      smac_q        <= smac_d;
      length_q      <= length_d;
      fcs_q         <= fcs_d;
      dout_q        <= dout_d;
      dout_valid_q  <= dout_valid_d;
      frame_done_q  <= frame_done_d;
      frame_error_q <= frame_error_d;
      err_code_q    <= err_code_d;
      busy_q        <= busy_d;
    end
  end

  assign dMAC       = dmac_q;
  assign sMAC       = smac_q;
  assign length     = length_q;
  assign FCS        = fcs_q;
  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign frameDone  = frame_done_q;
  assign frameError = frame_error_q;
  assign errCode    = err_code_q;
  assign busy       = busy_q;

endmodule
